// File: rtl/perf_counter_unit_pkg.sv
// Shared types for the performance-counter unit: counter width, divider states
// and the bundled counter record.
package perf_pkg;

    localparam int unsigned CNT_WIDTH_DEFAULT = 19;

    typedef logic [CNT_WIDTH_DEFAULT-1:0] cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } div_state_t;

    typedef struct packed {
        cnt_t cycles;
        cnt_t stalls;
        cnt_t ariths;
        cnt_t mems;
        cnt_t insts;
    } perf_counts_t;

endpackage

// File: rtl/perf_counter_unit_if.sv
// Event inputs and count/CPI outputs of the performance-counter unit.
// The slave side is the counter unit, the master side is the pipeline/register file.
interface perf_counter_unit_if #(
    parameter int unsigned W = perf_pkg::CNT_WIDTH_DEFAULT
);

    logic         stall_i;
    logic         arith_retire;
    logic         mem_retire;
    logic         inst_retire;
    logic         finish;
    logic [W-1:0] cycle_count;
    logic [W-1:0] stall_count;
    logic [W-1:0] aritmetric_count;
    logic [W-1:0] memory_count;
    logic [W-1:0] instruction_count;
    logic [W-1:0] cpi;
    logic         cpi_valid;

    modport master (
        output stall_i, arith_retire, mem_retire, inst_retire, finish,
        input  cycle_count, stall_count, aritmetric_count, memory_count,
               instruction_count, cpi, cpi_valid
    );

    modport slave (
        input  stall_i, arith_retire, mem_retire, inst_retire, finish,
        output cycle_count, stall_count, aritmetric_count, memory_count,
               instruction_count, cpi, cpi_valid
    );

endinterface

// File: rtl/perf_counter_unit_seq_divider.sv
// Start/busy restoring divider, one quotient bit per cycle MSB first; the quotient
// register and its sticky valid flag are written in the DONE state.
module seq_divider
    import perf_pkg::*;
#(
    parameter int unsigned W = CNT_WIDTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic [W-1:0] quotient,
    output logic         valid
);

    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;

    div_state_t    state_q, state_d;
    logic [W-1:0]  dvd_q, dvd_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [W:0]    rem_q, rem_d;
    logic [IW-1:0] iter_q, iter_d;
    logic [W-1:0]  quot_q, quot_d;
    logic          valid_q, valid_d;
    logic [W+1:0]  rem_sh;

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        iter_d  = iter_q;
        quot_d  = quot_q;
        valid_d = valid_q;
        rem_sh  = {rem_q, dvd_q[W-1]};
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DIV;
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    rem_d   = '0;
                    iter_d  = '0;
                end
            end
            DIV: begin
                // Dividend register doubles as the quotient shift register.
                if (rem_sh >= {2'b00, dvs_q}) begin
                    rem_d = rem_sh[W:0] - {1'b0, dvs_q};
                    dvd_d = {dvd_q[W-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[W:0];
                    dvd_d = {dvd_q[W-2:0], 1'b0};
                end
                iter_d = iter_q + 1'b1;
                if (iter_q == IW'(W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                quot_d  = dvd_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            iter_q  <= '0;
            quot_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            iter_q  <= iter_d;
            quot_q  <= quot_d;
            valid_q <= valid_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign quotient = quot_q;
    assign valid    = valid_q;

endmodule

// File: rtl/perf_counter_unit.sv
// Saturating cycle/stall/retire counters frozen by finish, plus a sequential CPI
// divider compiled in only when PERF_CPI_EN is defined (otherwise cpi/cpi_valid read 0).
module perf_counter_unit
    import perf_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
    input logic                clk,
    input logic                rst,
    perf_counter_unit_if.slave bus
);

    // Counters live in full-width package fields and cap at this instance's width.
    localparam cnt_t CNT_MAX = cnt_t'((64'd1 << CNT_WIDTH) - 64'd1);

    function automatic cnt_t sat_inc(input cnt_t v, input logic ev);
        return (ev && (v != CNT_MAX)) ? v + cnt_t'(1) : v;
    endfunction

    perf_counts_t counts_q, counts_d;

    always_comb begin
        counts_d = counts_q;
        if (!bus.finish) begin
            counts_d.cycles = sat_inc(counts_q.cycles, 1'b1);
            counts_d.stalls = sat_inc(counts_q.stalls, bus.stall_i);
            counts_d.ariths = sat_inc(counts_q.ariths, bus.arith_retire);
            counts_d.mems   = sat_inc(counts_q.mems,   bus.mem_retire);
            counts_d.insts  = sat_inc(counts_q.insts,  bus.inst_retire);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counts_q <= '0;
        end else begin
            counts_q <= counts_d;
        end
    end

    assign bus.cycle_count       = counts_q.cycles[CNT_WIDTH-1:0];
    assign bus.stall_count       = counts_q.stalls[CNT_WIDTH-1:0];
    assign bus.aritmetric_count  = counts_q.ariths[CNT_WIDTH-1:0];
    assign bus.memory_count      = counts_q.mems[CNT_WIDTH-1:0];
    assign bus.instruction_count = counts_q.insts[CNT_WIDTH-1:0];

`ifdef PERF_CPI_EN
    logic div_busy;
    logic div_start;

    assign div_start = !div_busy && (counts_q.insts != '0);

    seq_divider #(
        .W(CNT_WIDTH)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (counts_q.cycles[CNT_WIDTH-1:0]),
        .divisor  (counts_q.insts[CNT_WIDTH-1:0]),
        .busy     (div_busy),
        .quotient (bus.cpi),
        .valid    (bus.cpi_valid)
    );
`else
    assign bus.cpi       = '0;
    assign bus.cpi_valid = 1'b0;
`endif

endmodule
